// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner
// Control stage in front of an external 8:1 select mux (built as a 2:1 tree).
// It accepts one 8-bit word with a channel-enable mask and holds the word on
// the mux data inputs. It then steps the 3-bit select through the enabled
// channels, and the mux output goes downstream as one bit per transfer.
//
// Parameters:
//   SCAN_DESC  0: channels are visited in ascending index (0 -> 7)
//              1: channels are visited in descending index (7 -> 0)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word (IDLE and not in reset)
//   in_data    word to serialize
//   ch_mask    channel enable mask, sampled together with in_data
//   mux_a      registered word driven onto the mux data inputs
//   mux_sel    registered select driven onto the mux
//   mux_y      combinational output of the external mux
//   out_valid  serial bit valid (SCAN and not in reset)
//   out_ready  downstream accepts the bit
//   out_bit    pass-through of mux_y
//   out_ch     channel index of the current bit (same as mux_sel)
//   out_last   current bit is the final enabled channel of the word
//   empty_err  one-cycle pulse after a word with an all-zero mask is accepted
module mux_sel_scanner #(
  parameter bit SCAN_DESC = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] ch_mask,
  output logic [7:0] mux_a,
  output logic [2:0] mux_sel,
  input  logic       mux_y,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic [2:0] out_ch,
  output logic       out_last,
  output logic       empty_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] mask_q;
  logic [2:0] first_ch;
  logic [2:0] next_ch;
  logic       has_next;
  logic       accept;
  logic       xfer;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == SCAN) && !rst;
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign out_bit   = mux_y;
  assign out_ch    = mux_sel;
  assign out_last  = out_valid && !has_next;

  // Channel search. Each loop walks the indices opposite to the scan order,
  // so the last hit is the channel nearest the start of the scan. This gives
  // the first enabled channel of the new word and the next enabled channel
  // after the current select.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path can leave a value held (no inferred latch).
  always_comb begin
    first_ch = 3'd0;
    next_ch  = mux_sel;
    has_next = 1'b0;
    if (SCAN_DESC) begin
      for (int i = 0; i < 8; i++) begin
        if (ch_mask[i]) first_ch = 3'(i);
        if (mask_q[i] && (i < int'(mux_sel))) begin
          next_ch  = 3'(i);
          has_next = 1'b1;
        end
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (ch_mask[i]) first_ch = 3'(i);
        if (mask_q[i] && (i > int'(mux_sel))) begin
          next_ch  = 3'(i);
          has_next = 1'b1;
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (ch_mask != 8'h00)) state_next = SCAN;
      SCAN:    if (xfer && !has_next)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and there is no ordering race.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath registers. The word and the select stay frozen under
  // backpressure, and they keep their values after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mux_a     <= 8'h00;
      mux_sel   <= 3'd0;
      mask_q    <= 8'h00;
      empty_err <= 1'b0;
    end else begin
      empty_err <= 1'b0;
      if (accept) begin
        if (ch_mask != 8'h00) begin
          mux_a   <= in_data;
          mask_q  <= ch_mask;
          mux_sel <= first_ch;
        end else begin
          // All-zero mask: the word is consumed and flagged, but not scanned.
          empty_err <= 1'b1;
        end
      end else if (xfer && has_next) begin
        mux_sel <= next_ch;
      end
    end
  end

endmodule

// File: doc/mux_sel_scanner.md
Name: mux_sel_scanner

Overview:
- Upstream control stage for an 8:1 select mux built from a 2:1 tree.
- Accepts an 8-bit word and a channel-enable mask through a valid/ready handshake.
- Holds the word on the mux data inputs and steps the 3-bit select through the enabled channels.
- Returns the mux output to a downstream consumer as a serial bit stream with valid/ready, a channel tag and a last flag.

Parameters:
SCAN_DESC, 0, scan order: 0 = ascending channel index (0→7), 1 = descending (7→0)

Ports:
clk  input  1  single clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word
in_data  input  8  word to serialize
ch_mask  input  8  channel enable; bit i = 1 means channel i is scanned; sampled with in_data
mux_a  output  8  registered word driven onto the external mux data inputs
mux_sel  output  3  registered select driven onto the external mux
mux_y  input  1  combinational output of the external mux
out_valid  output  1  serial bit valid
out_ready  input  1  downstream accepts the bit
out_bit  output  1  equals mux_y (combinational pass-through)
out_ch  output  3  channel index of the current bit; equals mux_sel
out_last  output  1  current bit is the final enabled channel of the word
empty_err  output  1  one-cycle pulse: a word was accepted with ch_mask == 0

Behaviour:
- States: IDLE, SCAN. Registers: state, mux_a, mux_sel, mask_q, empty_err.
- Reset (rst high at an edge):
  - state = IDLE; mux_a = 8'h00; mux_sel = 3'd0; mask_q = 8'h00; empty_err = 0.
  - While rst is high: in_ready = 0 and out_valid = 0.
- in_ready = (state == IDLE) && !rst. Accept occurs when in_valid && in_ready.
- Accept at edge T with ch_mask != 0:
  - T+1: state = SCAN; mux_a = in_data; mask_q = ch_mask.
  - T+1: mux_sel = first set bit of ch_mask in scan order (lowest index if SCAN_DESC = 0, highest if 1).
- Accept at edge T with ch_mask == 0:
  - Word is consumed but not scanned; state stays IDLE; mux_a is unchanged.
  - empty_err = 1 for exactly the T+1 cycle.
- SCAN outputs: out_valid = 1; out_bit = mux_y; out_ch = mux_sel.
- out_last = 1 iff no set bit of mask_q lies beyond mux_sel in scan order.
- Transfer = out_valid && out_ready:
  - not last: next edge moves mux_sel to the next set bit of mask_q in scan order, skipping cleared bits; no wrap within a word.
  - last: next edge sets state = IDLE; mux_sel and mux_a keep their values.
- Backpressure: while out_ready = 0, mux_sel, mux_a and out_last are held stable; out_bit follows mux_y.
- Throughput: k enabled channels take k transfer cycles, then at least one IDLE cycle before the next accept. No accept in the same cycle as the last transfer.
- In SCAN, in_data and ch_mask are ignored because in_ready = 0.
- Reset mid-scan: next edge returns to IDLE; remaining channels are discarded; no out_last is issued.
- IDLE: out_valid = 0 and out_last = 0; out_bit and out_ch are don't-care for consumers.
- Select width is fixed at 3 bits; mux_sel never leaves 0..7.

Test Plan:
- Reset then full scan: rst for 2 cycles; in_data = 8'hA5, ch_mask = 8'hFF, out_ready = 1, SCAN_DESC = 0 → out_ch runs 0..7 on consecutive cycles; out_bit = 1,0,1,0,0,1,0,1; out_last only with ch 7; in_ready returns 1 the cycle after.
- Sparse mask: in_data = 8'h3C, ch_mask = 8'b1001_0010 → exactly 3 transfers on ch 1,4,7 with bits 0,1,0; out_last on ch 7.
- Descending: SCAN_DESC = 1, in_data = 8'h01, ch_mask = 8'h81 → transfers on ch 7 then ch 0; bits 0,1; out_last on ch 0.
- Backpressure: ch_mask = 8'h0F with out_ready low for 3 cycles at ch 2 → mux_sel holds 2 for those cycles; no channel skipped or repeated; 4 total transfers.
- Empty mask: ch_mask = 8'h00 with in_valid = 1 → in_ready stays 1; empty_err is high for exactly one cycle; out_valid never asserts; mux_a unchanged.
- Mid-scan reset: ch_mask = 8'hFF; rst pulsed after ch 3 transfer → next cycle out_valid = 0, mux_a = 8'h00, mux_sel = 0; the next word scans from its first enabled channel.
